// File: rtl/hippo_alu_issue.sv
// hippo_alu_issue: decodes RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC)
// into an ALU command and holds it in a two-entry buffer (output + skid).
// in_ready depends only on registered state, so there is no ready path
// from out_ready back to in_ready.
module hippo_alu_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [2:0]      op,
  output logic            sub_arith,
  output logic [4:0]      rd,
  output logic            illegal
);

  localparam int unsigned CmdW = 2 * XLEN + 10;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] F7Zero   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Sr     = 3'b101;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [2:0]      w_op;
  logic            w_sub;
  logic [4:0]      w_rd;
  logic            w_ill;
  logic [CmdW-1:0] w_cmd;
  logic            w_in_fire;
  logic            w_out_fire;

  logic            r_out_valid;
  logic            r_skid_valid;
  logic [CmdW-1:0] r_out_cmd;
  logic [CmdW-1:0] r_skid_cmd;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];

  // Decode the offered instruction; anything unrecognised stays an all-zero illegal command.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_op  = AluAdd;
    w_sub = 1'b0;
    w_rd  = 5'd0;
    w_ill = 1'b1;
    case (w_opcode)
      OpcOp: begin
        if (w_f7 == F7Zero || (w_f7 == F7Alt && (w_f3 == AluAdd || w_f3 == F3Sr))) begin
          w_a   = rs1_val;
          w_b   = rs2_val;
          w_op  = w_f3;
          w_sub = instr[30];
          w_rd  = instr[11:7];
          w_ill = 1'b0;
        end
      end
      OpcOpImm: begin
        if (w_f3 == F3Sll || w_f3 == F3Sr) begin
          // Shifts carry shamt in the immediate and use funct7 to pick SRA/SRL.
          if (w_f7 == F7Zero || (w_f7 == F7Alt && w_f3 == F3Sr)) begin
            w_a   = rs1_val;
            w_b   = XLEN'(instr[24:20]);
            w_op  = w_f3;
            w_sub = (w_f3 == F3Sr) ? instr[30] : 1'b0;
            w_rd  = instr[11:7];
            w_ill = 1'b0;
          end
        end else begin
          w_a   = rs1_val;
          w_b   = {{(XLEN-12){instr[31]}}, instr[31:20]};
          w_op  = w_f3;
          w_rd  = instr[11:7];
          w_ill = 1'b0;
        end
      end
      OpcLui: begin
        w_b   = XLEN'({instr[31:12], 12'b0});
        w_rd  = instr[11:7];
        w_ill = 1'b0;
      end
      OpcAuipc: begin
        w_a   = pc;
        w_b   = XLEN'({instr[31:12], 12'b0});
        w_rd  = instr[11:7];
        w_ill = 1'b0;
      end
      default: ;
    endcase
  end

  assign w_cmd      = {w_a, w_b, w_op, w_sub, w_rd, w_ill};
  assign in_ready   = !r_skid_valid && !rst;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Two-entry FIFO: skid refills the output first; new commands fill output when it frees up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_cmd    <= '0;
      r_skid_cmd   <= '0;
    end else if (r_skid_valid) begin
      if (w_out_fire) begin
        r_out_cmd    <= r_skid_cmd;
        r_skid_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      if (!r_out_valid || w_out_fire) begin
        r_out_cmd   <= w_cmd;
        r_out_valid <= 1'b1;
      end else begin
        r_skid_cmd   <= w_cmd;
        r_skid_valid <= 1'b1;
      end
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign {a, b, op, sub_arith, rd, illegal} = r_out_cmd;

endmodule

// File: tb/tb_hippo_alu_issue.sv
// Self-checking bench for hippo_alu_issue: directed vectors plus randomized traffic
// checked against a queue-based reference of the two-entry command buffer.
module tb_hippo_alu_issue;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        sub;
    logic [4:0]  rd;
    logic        ill;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [31:0] pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        sub_arith;
  logic [4:0]  rd;
  logic        illegal;

  int   n_cmp = 0;
  int   n_err = 0;
  cmd_t q[$];

  hippo_alu_issue #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .sub_arith (sub_arith),
    .rd        (rd),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode from the instruction-set rules, using plain arithmetic on the word.
  function automatic cmd_t ref_decode(input logic [31:0] ins, input logic [31:0] r1,
                                      input logic [31:0] r2, input logic [31:0] p);
    cmd_t        c;
    int unsigned opc;
    int unsigned f3;
    int unsigned f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    bit          legal;
    opc   = ins & 32'h7f;
    f3    = (ins >> 12) & 7;
    f7    = ins >> 25;
    imm_i = $signed(ins) >>> 20;
    imm_u = ins & 32'hFFFF_F000;
    legal = 0;
    c     = '0;
    c.rd  = 5'((ins >> 7) & 31);
    if (opc == 'h33) begin
      legal = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
      c.a = r1; c.b = r2; c.op = 3'(f3); c.sub = (f7 == 'h20);
    end else if (opc == 'h13) begin
      c.a = r1; c.op = 3'(f3);
      if (f3 == 1) begin
        legal = (f7 == 0); c.b = (ins >> 20) & 31;
      end else if (f3 == 5) begin
        legal = (f7 == 0) || (f7 == 'h20); c.b = (ins >> 20) & 31; c.sub = (f7 == 'h20);
      end else begin
        legal = 1; c.b = imm_i;
      end
    end else if (opc == 'h37) begin
      legal = 1; c.b = imm_u;
    end else if (opc == 'h17) begin
      legal = 1; c.a = p; c.b = imm_u;
    end
    if (!legal) begin
      c     = '0;
      c.ill = 1'b1;
    end
    return c;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  f7;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       opc = 7'h33;
      1, 2:    opc = 7'h13;
      3:       opc = 7'h37;
      4:       opc = 7'h17;
      default: opc = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], opc};
  endfunction

  // One clock cycle: drive, check against the model, then advance the model at the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] p, input logic ordy,
                      input logic rs);
    logic in_fire;
    logic out_fire;
    cmd_t e;
    @(negedge clk);
    rst = rs; in_valid = v; instr = ins; rs1_val = r1; rs2_val = r2; pc = p;
    out_ready = ordy;
    #1;
    check("in_ready", {31'b0, in_ready}, {31'b0, (!rs && q.size() < 2)});
    check("out_valid", {31'b0, out_valid}, {31'b0, (q.size() > 0)});
    if (out_valid && q.size() > 0) begin
      e = q[0];
      check("a", a, e.a);
      check("b", b, e.b);
      check("op", {29'b0, op}, {29'b0, e.op});
      check("sub_arith", {31'b0, sub_arith}, {31'b0, e.sub});
      check("rd", {27'b0, rd}, {27'b0, e.rd});
      check("illegal", {31'b0, illegal}, {31'b0, e.ill});
    end
    in_fire  = v && in_ready;
    out_fire = out_valid && ordy;
    @(posedge clk);
    if (rs) begin
      q.delete();
    end else begin
      if (out_fire && q.size() > 0) void'(q.pop_front());
      if (in_fire) q.push_back(ref_decode(ins, r1, r2, p));
    end
  endtask

  // Direct look at the outputs shortly after an edge, against hand-derived constants.
  task automatic expect_out(input string tag, input cmd_t e);
    #2;
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".a"}, a, e.a);
    check({tag, ".b"}, b, e.b);
    check({tag, ".op"}, {29'b0, op}, {29'b0, e.op});
    check({tag, ".sub"}, {31'b0, sub_arith}, {31'b0, e.sub});
    check({tag, ".rd"}, {27'b0, rd}, {27'b0, e.rd});
    check({tag, ".ill"}, {31'b0, illegal}, {31'b0, e.ill});
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state while rst is held.
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.in_ready", {31'b0, in_ready}, 32'd0);
    check("rst.a", a, 32'd0);
    check("rst.b", b, 32'd0);
    check("rst.op", {29'b0, op}, 32'd0);
    check("rst.rd", {27'b0, rd}, 32'd0);
    check("rst.ill", {31'b0, illegal}, 32'd0);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);

    // Directed decode vectors.
    step(1'b1, 32'h002081B3, 32'd3, 32'd5, 32'h100, 1'b1, 1'b0);
    expect_out("add", '{a: 32'd3, b: 32'd5, op: 3'd0, sub: 1'b0, rd: 5'd3, ill: 1'b0});
    step(1'b1, 32'h40235293, 32'hFFFFFFF4, 32'd0, 32'h104, 1'b1, 1'b0);
    expect_out("srai", '{a: 32'hFFFFFFF4, b: 32'd2, op: 3'd5, sub: 1'b1, rd: 5'd5, ill: 1'b0});
    step(1'b1, 32'hFFD00093, 32'h55, 32'd0, 32'h108, 1'b1, 1'b0);
    expect_out("addi", '{a: 32'h55, b: 32'hFFFFFFFD, op: 3'd0, sub: 1'b0, rd: 5'd1, ill: 1'b0});
    step(1'b1, 32'h123450B7, 32'h77, 32'd0, 32'h10C, 1'b1, 1'b0);
    expect_out("lui", '{a: 32'd0, b: 32'h12345000, op: 3'd0, sub: 1'b0, rd: 5'd1, ill: 1'b0});
    step(1'b1, 32'h00000073, 32'h11, 32'h22, 32'h110, 1'b1, 1'b0);
    expect_out("ill_sys", '{a: 32'd0, b: 32'd0, op: 3'd0, sub: 1'b0, rd: 5'd0, ill: 1'b1});
    step(1'b1, 32'h402091B3, 32'h11, 32'h22, 32'h114, 1'b1, 1'b0);
    expect_out("ill_f7", '{a: 32'd0, b: 32'd0, op: 3'd0, sub: 1'b0, rd: 5'd0, ill: 1'b1});
    drain();

    // Backpressure: three offers with out_ready low, then release.
    step(1'b1, 32'h002081B3, 32'd1, 32'd2, '0, 1'b0, 1'b0);
    step(1'b1, 32'h002081B3, 32'd3, 32'd4, '0, 1'b0, 1'b0);
    step(1'b1, 32'h002081B3, 32'd5, 32'd6, '0, 1'b0, 1'b0);
    check("bp.in_ready_low", {31'b0, in_ready}, 32'd0);
    step(1'b1, 32'h002081B3, 32'd5, 32'd6, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    drain();

    // Reset with both entries occupied.
    step(1'b1, 32'h00A00093, 32'd9, '0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h00B00093, 32'd9, '0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h00C00093, 32'd9, '0, '0, 1'b0, 1'b1);
    #2;
    check("rstmid.out_valid", {31'b0, out_valid}, 32'd0);
    check("rstmid.in_ready", {31'b0, in_ready}, 32'd0);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
